// File: rtl/wb_ram.sv
// wb_ram: word-addressed single-port RAM slave for the core's Wishbone-style
// bus. Each accepted strobe waits LATENCY cycles, then gets a one-cycle ack
// (or err). Depth is 2**ADDR_BITS 32-bit words. Byte lanes follow sel_i.
//
// Handshake: a strobe is accepted in IDLE when stb_i & cyc_i are high and no
// termination pulse is being driven. The master keeps stb_i/cyc_i high until
// it sees ack_o/err_o. Dropping either one during the wait phase abandons
// the access: no termination is sent and nothing is written.
//
// Optional feature WBRAM_RANGE_ERR_EN: addresses whose upper bits do not match
// BASE get err_o instead of ack_o. They neither write memory nor change dat_o.
// Without it, the upper address bits are ignored and memory aliases.
module wb_ram #(
  parameter int          ADDR_BITS = 10,
  parameter logic [31:0] BASE      = 32'h0000_1000,
  parameter int          LATENCY   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic        wen_i,
  input  logic [3:0]  sel_i,
  input  logic        stb_i,
  input  logic        cyc_i,
  output logic        ack_o,
  output logic        err_o,
  output logic        rty_o
);

  localparam int         DEPTH = 2 ** ADDR_BITS;
  localparam logic [3:0] LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Current FSM state; kept as a named signal so checkers can bind to it.
  state_t state;

  logic [31:0]          mem [DEPTH];
  logic [3:0]           cnt;
  logic [ADDR_BITS-1:0] idx_q;
  logic [31:0]          dat_q;
  logic                 wen_q;
  logic [3:0]           sel_q;
  logic                 inrange_q;
  logic                 inrange_d;
  logic                 accept;

  assign rty_o  = 1'b0;
  assign accept = stb_i && cyc_i && !ack_o && !err_o;

`ifdef WBRAM_RANGE_ERR_EN
  assign inrange_d = (adr_i[31:ADDR_BITS] == BASE[31:ADDR_BITS]);
`else
  assign inrange_d = 1'b1;
`endif

  // These upper bits only matter when the range check is compiled in.
  logic unused_bits;
  assign unused_bits = ^{adr_i[31:ADDR_BITS], BASE[31:ADDR_BITS]};

  // Control FSM: capture, wait-state countdown, and registered termination.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      ack_o <= 1'b0;
      err_o <= 1'b0;
      dat_o <= 32'd0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            idx_q     <= adr_i[ADDR_BITS-1:0];
            dat_q     <= dat_i;
            wen_q     <= wen_i;
            sel_q     <= sel_i;
            inrange_q <= inrange_d;
            cnt       <= LAT;
            state     <= (LAT != 4'd0) ? WAIT : RESP;
          end
        end
        WAIT: begin
          if (!stb_i || !cyc_i) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
          if (!inrange_q) begin
            err_o <= 1'b1;
          end else begin
            ack_o <= 1'b1;
            if (!wen_q) dat_o <= mem[idx_q];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Byte-lane write, committed on the same edge that raises ack_o.
  always_ff @(posedge clk) begin
    if (!reset && state == RESP && wen_q && inrange_q) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_q[b]) mem[idx_q][8*b +: 8] <= dat_q[8*b +: 8];
      end
    end
  end

endmodule
